bomb_pool: RTL and testbench
============================

# bomb_pool

Pool of `NUM_BOMBS` independent falling projectiles that replaces the single-bomb object in the Space Invaders VGA pipeline. Each frame it accepts at most one launch request carrying a monster position. It places the request in the lowest-index free slot and moves every active slot down at a fixed-point speed. A slot is retired when it passes the bottom line or receives a per-slot collision. Per-slot coordinates and an active mask feed the bomb drawing and collision logic.

## Interface
- `NUM_BOMBS`, 4: number of slots, 1..16.
- `FP_SHIFT`, 6: fixed-point fraction bits; the multiplier is 2^FP_SHIFT.
- `Y_SPEED`, 200: downward speed per frame, in fixed-point units.
- `BOTTOM_Y`, 460: a slot retires when its pixel Y is greater than this value.
- `X_ALIGN_MASK`, 11'h7fc: mask applied to `launchX` at spawn.
- `COOLDOWN_FRAMES`, 8: minimum number of frames between two accepted launches, 0..255.
- `EXPLODE_FRAMES`, 6: number of frames a hit slot stays in EXPLODING (used only when the macro is defined).
- `clk`, input, 1: system clock. One clock only.
- `resetN`, input, 1: asynchronous, active-low reset.
- `startOfFrame`, input, 1: one-cycle pulse at the start of each frame.
- `launchReq`, input, 1: level request to spawn a bomb.
- `launchX`, `launchY`, input, 11 each: spawn pixel position.
- `launchAck`, output, 1: one-cycle pulse confirming that a launch was accepted.
- `collision`, input, NUM_BOMBS: per-slot hit indication.
- `topLeftX`, `topLeftY`, output, NUM_BOMBS×11 signed, packed with slot i at bits [11i+10:11i]: pixel position of each slot.
- `activeMask`, output, NUM_BOMBS: slot is FALLING or EXPLODING.
- `explodingMask`, output, NUM_BOMBS: slot is EXPLODING.
- `freeCount`, output, 5: number of IDLE slots.

## Operation
- Each slot has three states: IDLE, FALLING and EXPLODING. It stores a signed 32-bit `yFp`, a 32-bit `xFp` and a 4-bit `expCnt`.
- **Spawn.** A spawn occurs on the `startOfFrame` cycle when all of the following hold:
  - `launchReq` is 1,
  - `cooldown` is 0,
  - at least one slot is IDLE.
- **Spawn effects.**
  - The lowest-index IDLE slot moves to FALLING.
  - That slot loads `xFp = (launchX & X_ALIGN_MASK) << FP_SHIFT` and `yFp = launchY << FP_SHIFT`.
  - `cooldown` loads `COOLDOWN_FRAMES`.
  - `launchAck` pulses high.
  - If no spawn occurs, `cooldown` decrements once per frame and saturates at 0.
- **Fall.** On each `startOfFrame`, every FALLING slot that was not spawned in the same cycle adds `Y_SPEED` to `yFp`.
  - If the pre-update `yFp` is greater than `BOTTOM_Y << FP_SHIFT`, the slot goes to IDLE instead.
- **Hit.** When `collision[i]` is 1 and slot i is FALLING, slot i goes to EXPLODING with `expCnt = EXPLODE_FRAMES`, and its position freezes.
  - Collision has priority over fall or retire in the same cycle.
  - Collision on an IDLE or EXPLODING slot is ignored.
- **Explode.** On each `startOfFrame`, `expCnt` decrements; when the count reaches 0, the slot goes to IDLE.
- **Outputs.**
  - `topLeftX = xFp >>> FP_SHIFT` and `topLeftY = yFp >>> FP_SHIFT` (arithmetic shift), truncated to 11 bits.
  - An IDLE slot holds its last position; consumers must qualify the position with `activeMask`.
- **Arithmetic.** `yFp` is signed 32-bit and never wraps within the screen range. A slot is never observed past 2047 px, because retirement fires first.

## Timing
- **Reset values:**
  - every slot IDLE, with `xFp = yFp = 0` and `expCnt = 0`;
  - `cooldown = 0`;
  - `launchAck = 0`, `activeMask = 0`, `explodingMask = 0`;
  - `freeCount = NUM_BOMBS`;
  - all positions 0.
- All state updates are registered on the `startOfFrame` or `collision` cycle. Outputs reflect the change one clock later.
  - `launchAck` is high exactly on the cycle after the accepting `startOfFrame`.
- The requester holds `launchReq` until it sees `launchAck`. A request that is not acknowledged is simply retried on the next frame.
- A newly spawned slot does not move in its spawn frame. It first moves on the next `startOfFrame`.
- Asserting `resetN` mid-flight clears all slots immediately (asynchronously). No acknowledge is produced.
- **Pool full:** the request is not accepted, no `launchAck` pulse occurs, and `cooldown` is unchanged.

## Configuration
- Macro `BOMB_POOL_EXPLODE_EN`.
- **Defined:** the EXPLODING state exists as described above.
- **Undefined:** a collision sends the slot straight from FALLING to IDLE. `explodingMask` is tied to 0, and `expCnt` and `EXPLODE_FRAMES` are unused.

## Structure
- Package `bomb_pkg`:
  - enum `bomb_state_t` {IDLE, FALLING, EXPLODING},
  - constants `SCREEN_W_BITS = 11` and `FP_W = 32`.
- Sub-module `bomb_slot`: one slot's state machine and position, instantiated `NUM_BOMBS` times with a generate loop.
- The top level holds:
  - the lowest-index free-slot priority encoder,
  - the cooldown counter,
  - `launchAck`,
  - the `freeCount` popcount.

## Test plan
- **Reset then spawn.** Reset, then `launchReq` = 1 with X = 103, Y = 40 at a frame pulse. Expected: slot 0 active, `topLeftX` = 100, `topLeftY` = 40, one `launchAck` pulse. After 10 more frames, `topLeftY` = 40 + (10·200)/64 = 71.
- **Cooldown.** `launchReq` held high with `COOLDOWN_FRAMES` = 8. Expected: acknowledges on frames 0, 9, 18, 27; slots 0..3 filled in order; `freeCount` 4→0. A 5th request gets no acknowledge while the pool is full.
- **Retirement at the bottom.** Spawn at Y = 455. Expected: still active while the pre-update pixel Y ≤ 460. Retires on the first frame whose pre-update pixel Y > 460; `activeMask` bit drops and `freeCount` increments.
- **Collision and frame in the same cycle.** `collision[1]` coincides with `startOfFrame`. Expected: slot 1 goes to EXPLODING with its position unchanged. It goes to IDLE after 6 further frames; with the macro undefined it goes to IDLE immediately.
- **Collision on an idle slot.** `collision[2]` while slot 2 is IDLE. Expected: no state change, and the next spawn still selects slot 2 if it is the lowest free slot.
- **Reset mid-operation.** `resetN` low during flight. Expected: all masks 0, `freeCount` = 4, no `launchAck` pulse.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared types for the bomb pool: slot states and datapath widths.
// The optional EXPLODING behaviour is enabled with BOMB_POOL_EXPLODE_EN.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FALLING,
    EXPLODING
  } bomb_state_t;

  localparam int SCREEN_W_BITS = 11;
  localparam int FP_W          = 32;

endpackage

// File: rtl/bomb_slot.sv
// One falling-bomb slot: state machine plus fixed-point position.
// EXPLODING countdown is present only with BOMB_POOL_EXPLODE_EN.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int                       FP_SHIFT       = 6,
  parameter int                       Y_SPEED        = 200,
  parameter int                       BOTTOM_Y       = 460,
  parameter logic [SCREEN_W_BITS-1:0] X_ALIGN_MASK   = 11'h7fc,
  parameter int                       EXPLODE_FRAMES = 6
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic                            spawn,
  input  logic                            collision,
  input  logic [SCREEN_W_BITS-1:0]        launchX,
  input  logic [SCREEN_W_BITS-1:0]        launchY,
  output bomb_state_t                     state,
  output logic signed [SCREEN_W_BITS-1:0] topLeftX,
  output logic signed [SCREEN_W_BITS-1:0] topLeftY
);

  localparam logic signed [FP_W-1:0] BOTTOM_FP =
    FP_W'(BOTTOM_Y * (2 ** FP_SHIFT));
  localparam logic signed [FP_W-1:0] Y_STEP = FP_W'(Y_SPEED);

  bomb_state_t             state_q, state_d;
  logic [FP_W-1:0]         x_q, x_d;
  logic signed [FP_W-1:0]  y_q, y_d;
`ifdef BOMB_POOL_EXPLODE_EN
  logic [3:0]              cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef BOMB_POOL_EXPLODE_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d = FALLING;
          x_d = FP_W'(launchX & X_ALIGN_MASK) << FP_SHIFT;
          y_d = $signed(FP_W'(launchY)) <<< FP_SHIFT;
        end
      end
      FALLING: begin
        // a hit freezes the position, overriding fall and retire
        if (collision) begin
`ifdef BOMB_POOL_EXPLODE_EN
          state_d = EXPLODING;
          cnt_d   = 4'(EXPLODE_FRAMES);
`else
          state_d = IDLE;
`endif
        end else if (startOfFrame) begin
          if (y_q > BOTTOM_FP) state_d = IDLE;
          else                 y_d = y_q + Y_STEP;
        end
      end
      EXPLODING: begin
`ifdef BOMB_POOL_EXPLODE_EN
        if (startOfFrame) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
`ifdef BOMB_POOL_EXPLODE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef BOMB_POOL_EXPLODE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign state    = state_q;
  assign topLeftX = SCREEN_W_BITS'(x_q >> FP_SHIFT);
  assign topLeftY = SCREEN_W_BITS'(y_q >>> FP_SHIFT);

endmodule

// File: rtl/bomb_pool.sv
// Pool of independent falling bombs with launch cooldown and free count.
// Define BOMB_POOL_EXPLODE_EN to keep hit slots in an EXPLODING phase.
module bomb_pool
  import bomb_pkg::*;
#(
  parameter int                       NUM_BOMBS       = 4,
  parameter int                       FP_SHIFT        = 6,
  parameter int                       Y_SPEED         = 200,
  parameter int                       BOTTOM_Y        = 460,
  parameter logic [SCREEN_W_BITS-1:0] X_ALIGN_MASK    = 11'h7fc,
  parameter int                       COOLDOWN_FRAMES = 8,
  parameter int                       EXPLODE_FRAMES  = 6
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     launchReq,
  input  logic [SCREEN_W_BITS-1:0] launchX,
  input  logic [SCREEN_W_BITS-1:0] launchY,
  output logic                     launchAck,
  input  logic [NUM_BOMBS-1:0]     collision,
  output logic signed [NUM_BOMBS*SCREEN_W_BITS-1:0] topLeftX,
  output logic signed [NUM_BOMBS*SCREEN_W_BITS-1:0] topLeftY,
  output logic [NUM_BOMBS-1:0]     activeMask,
  output logic [NUM_BOMBS-1:0]     explodingMask,
  output logic [4:0]               freeCount
);

  logic [NUM_BOMBS-1:0] idle;
  logic [NUM_BOMBS-1:0] sel;
  logic [7:0]           cooldown;
  logic                 spawn_ok;

  // isolate the lowest set bit: lowest-index free slot
  assign sel = idle & (~idle + NUM_BOMBS'(1));

  assign spawn_ok = startOfFrame & launchReq
                  & (cooldown == 8'd0) & (|idle);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown  <= '0;
      launchAck <= 1'b0;
    end else begin
      launchAck <= spawn_ok;
      if (startOfFrame) begin
        if (spawn_ok)
          cooldown <= 8'(COOLDOWN_FRAMES);
        else if (!(launchReq && !(|idle)) && cooldown != 8'd0)
          cooldown <= cooldown - 8'd1;
      end
    end
  end

  always_comb begin
    freeCount = '0;
    for (int i = 0; i < NUM_BOMBS; i++)
      freeCount = freeCount + 5'(idle[i]);
  end

  for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
    bomb_state_t st;

    bomb_slot #(
      .FP_SHIFT      (FP_SHIFT),
      .Y_SPEED       (Y_SPEED),
      .BOTTOM_Y      (BOTTOM_Y),
      .X_ALIGN_MASK  (X_ALIGN_MASK),
      .EXPLODE_FRAMES(EXPLODE_FRAMES)
    ) u_slot (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .spawn       (spawn_ok & sel[i]),
      .collision   (collision[i]),
      .launchX     (launchX),
      .launchY     (launchY),
      .state       (st),
      .topLeftX    (topLeftX[i*SCREEN_W_BITS +: SCREEN_W_BITS]),
      .topLeftY    (topLeftY[i*SCREEN_W_BITS +: SCREEN_W_BITS])
    );

    assign idle[i]       = (st == IDLE);
    assign activeMask[i] = (st != IDLE);
`ifdef BOMB_POOL_EXPLODE_EN
    assign explodingMask[i] = (st == EXPLODING);
`endif
  end

`ifndef BOMB_POOL_EXPLODE_EN
  assign explodingMask = '0;
`endif

endmodule

// File: tb/tb_bomb_pool.sv
// Self-checking bench for bomb_pool: directed table, corner sequences
// and randomized frames against a slot-level reference model.
module tb_bomb_pool;

  localparam int N    = 4;
  localparam int EXPL = 6;
`ifdef BOMB_POOL_EXPLODE_EN
  localparam int HIT_FRAMES = EXPL;
`else
  localparam int HIT_FRAMES = 0;
`endif

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              launchReq = 1'b0;
  logic [10:0]       launchX = '0;
  logic [10:0]       launchY = '0;
  logic              launchAck;
  logic [N-1:0]      collision = '0;
  logic [N*11-1:0]   topLeftX;
  logic [N*11-1:0]   topLeftY;
  logic [N-1:0]      activeMask;
  logic [N-1:0]      explodingMask;
  logic [4:0]        freeCount;

  always #5 clk = ~clk;

  bomb_pool dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .launchReq    (launchReq),
    .launchX      (launchX),
    .launchY      (launchY),
    .launchAck    (launchAck),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .activeMask   (activeMask),
    .explodingMask(explodingMask),
    .freeCount    (freeCount)
  );

  int checks = 0;
  int passes = 0;

  // model: 0 idle, 1 falling, 2 exploding; positions in 1/64 px
  int     m_st[N];
  longint m_x[N];
  longint m_y[N];
  int     m_cnt[N];
  int     m_cd;
  bit     m_ack;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0;
    end
    m_cd = 0;
    m_ack = 0;
  endfunction

  function automatic void m_frame(bit sof, bit req, int lx, int ly,
                                  logic [N-1:0] coll);
    int k = -1;
    int nfree = 0;
    bit ok;
    for (int i = 0; i < N; i++)
      if (m_st[i] == 0) begin
        nfree++;
        if (k < 0) k = i;
      end
    ok = sof && req && m_cd == 0 && nfree > 0;
    m_ack = ok;
    for (int i = 0; i < N; i++) begin
      if (ok && i == k) begin
        m_st[i] = 1;
        m_x[i] = longint'(lx & 'h7fc) * 64;
        m_y[i] = longint'(ly) * 64;
      end else if (m_st[i] == 1) begin
        if (coll[i]) begin
`ifdef BOMB_POOL_EXPLODE_EN
          m_st[i] = 2;
          m_cnt[i] = EXPL;
`else
          m_st[i] = 0;
`endif
        end else if (sof) begin
          if (m_y[i] > 460 * 64) m_st[i] = 0;
          else m_y[i] += 200;
        end
      end else if (m_st[i] == 2 && sof) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_st[i] = 0;
      end
    end
    if (sof) begin
      if (ok) m_cd = 8;
      else if (!(req && nfree == 0) && m_cd > 0) m_cd--;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare_all();
    int act_e = 0;
    int exp_e = 0;
    int free_e = 0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] != 0) act_e |= (1 << i);
      if (m_st[i] == 2) exp_e |= (1 << i);
      if (m_st[i] == 0) free_e++;
    end
    chk("ack", int'(launchAck), int'(m_ack));
    chk("activeMask", int'(activeMask), act_e);
    chk("explodingMask", int'(explodingMask), exp_e);
    chk("freeCount", int'(freeCount), free_e);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("x%0d", i), int'(topLeftX[i*11 +: 11]),
          int'((m_x[i] >> 6) & 'h7ff));
      chk($sformatf("y%0d", i), int'(topLeftY[i*11 +: 11]),
          int'((m_y[i] >> 6) & 'h7ff));
    end
  endtask

  task automatic step(bit sof, bit req, int lx, int ly,
                      logic [N-1:0] coll);
    @(negedge clk);
    startOfFrame = sof;
    launchReq = req;
    launchX = 11'(lx);
    launchY = 11'(ly);
    collision = coll;
    m_frame(sof, req, lx, ly, coll);
    @(negedge clk);
    startOfFrame = 1'b0;
    launchReq = 1'b0;
    collision = '0;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit       sof;
    bit       req;
    int       lx;
    int       ly;
    logic [3:0] coll;
    bit       ack;
    logic [3:0] act;
    logic [3:0] expl;
    int       free;
    int       y0;
  } vec_t;

  vec_t tbl[$];
  int   yv[10] = '{43, 46, 49, 52, 55, 58, 61, 65, 68, 71};

  initial begin
    tbl.push_back('{1, 1, 103, 40, 4'b0, 1, 4'b0001, 4'b0, 3, 40});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1, 0, 0, 0, 4'b0, 0, 4'b0001, 4'b0, 3, yv[k]});
    tbl.push_back('{1, 1, 200, 10, 4'b0, 1, 4'b0011, 4'b0, 2, 74});
    tbl.push_back('{0, 0, 0, 0, 4'b0100, 0, 4'b0011, 4'b0, 2, 74});
`ifdef BOMB_POOL_EXPLODE_EN
    tbl.push_back('{1, 0, 0, 0, 4'b0010, 0, 4'b0011, 4'b0010, 2, 77});
`else
    tbl.push_back('{1, 0, 0, 0, 4'b0010, 0, 4'b0001, 4'b0, 3, 77});
`endif

    // reset state
    do_reset();
    compare_all();

    // directed table: spawn, fall, second spawn, idle hit, hit on frame
    foreach (tbl[v]) begin
      step(tbl[v].sof, tbl[v].req, tbl[v].lx, tbl[v].ly, tbl[v].coll);
      chk($sformatf("t%0d_ack", v), int'(launchAck), int'(tbl[v].ack));
      chk($sformatf("t%0d_act", v), int'(activeMask), int'(tbl[v].act));
      chk($sformatf("t%0d_expl", v), int'(explodingMask),
          int'(tbl[v].expl));
      chk($sformatf("t%0d_free", v), int'(freeCount), tbl[v].free);
      chk($sformatf("t%0d_y0", v), int'(topLeftY[10:0]), tbl[v].y0);
    end
    chk("t_x0", int'(topLeftX[10:0]), 100);
    chk("t_y1", int'(topLeftY[21:11]), 10);

    // cooldown with launchReq held, then pool full
    begin
      int acks[$];
      do_reset();
      for (int f = 0; f < 40; f++) begin
        step(1, 1, int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 300)), '0);
        if (launchAck) acks.push_back(f);
      end
      chk("cd_ack_count", acks.size(), 4);
      for (int j = 0; j < acks.size() && j < 4; j++)
        chk($sformatf("cd_ack%0d", j), acks[j], j * 9);
      chk("cd_full_free", int'(freeCount), 0);
      chk("cd_full_act", int'(activeMask), 15);
    end

    // retirement at the bottom line
    do_reset();
    step(1, 1, 8, 455, '0);
    chk("ret_f0_act", int'(activeMask[0]), 1);
    step(1, 0, 0, 0, '0);
    chk("ret_f1_y", int'(topLeftY[10:0]), 458);
    step(1, 0, 0, 0, '0);
    chk("ret_f2_y", int'(topLeftY[10:0]), 461);
    chk("ret_f2_act", int'(activeMask[0]), 1);
    step(1, 0, 0, 0, '0);
    chk("ret_f3_act", int'(activeMask[0]), 0);
    chk("ret_f3_free", int'(freeCount), 4);

    // hit coincident with a frame, then count frames to idle
    begin
      int n = 0;
      do_reset();
      step(1, 1, 50, 100, '0);
      repeat (8) step(1, 0, 0, 0, '0);
      step(1, 1, 60, 100, '0);
      chk("hit_spawn_ack", int'(launchAck), 1);
      step(1, 0, 0, 0, 4'b0010);
      chk("hit_frozen_y", int'(topLeftY[21:11]), 100);
      while (activeMask[1] && n < 20) begin
        step(1, 0, 0, 0, '0);
        n++;
      end
      chk("hit_frames", n, HIT_FRAMES);
    end

    // collision on idle slot 2 must not disturb its selection
    do_reset();
    step(1, 1, 10, 20, '0);
    repeat (8) step(1, 0, 0, 0, '0);
    step(1, 1, 30, 20, '0);
    repeat (8) step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 4'b0100);
    chk("idlehit_act", int'(activeMask), 3);
    step(1, 1, 40, 20, 4'b0100);
    chk("idlehit_sel", int'(activeMask), 7);
    chk("idlehit_ack", int'(launchAck), 1);

    // asynchronous reset mid-flight during an acceptable frame
    repeat (8) step(1, 0, 0, 0, '0);
    @(negedge clk);
    startOfFrame = 1'b1;
    launchReq = 1'b1;
    #2 resetN = 1'b0;
    #1 chk("rst_async_act", int'(activeMask), 0);
    @(posedge clk);
    #1;
    chk("rst_ack", int'(launchAck), 0);
    chk("rst_free", int'(freeCount), 4);
    chk("rst_expl", int'(explodingMask), 0);
    @(negedge clk);
    startOfFrame = 1'b0;
    launchReq = 1'b0;
    resetN = 1'b1;
    m_reset();
    compare_all();

    // randomized frames against the model
    for (int r = 0; r < 400; r++) begin
      logic [N-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
           c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
